// File: rtl/spmm_tile_sequencer.sv
// Control sequencer for the SpMM tile datapath: loads the RHS buffer in
// 4-row beats, streams LHS beats through the PE array, captures result rows
// into the output buffer and drains them in 4-row beats, with optional RHS
// reuse across consecutive LHS tiles.
module spmm_tile_sequencer #(
    parameter int N        = 16,
    parameter int PE_DELAY = 2,
    parameter int BW       = $clog2(N/4),
    parameter int RW       = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          rhs_ready,
    input  logic          rhs_start,
    output logic          rhs_we,
    output logic [BW-1:0] rhs_beat,
    output logic          lhs_ready,
    input  logic          lhs_start,
    input  logic          keep_rhs,
    output logic          pe_clear,
    output logic          pe_en,
    output logic [RW-1:0] lhs_beat,
    output logic          cap_en,
    output logic [RW-1:0] cap_row,
    output logic          out_ready,
    input  logic          out_start,
    output logic [BW-1:0] out_beat,
    output logic          tile_done,
    output logic          busy
);

    // Counter wide enough for 0..N+PE_DELAY-1 and for the comparison against N
    localparam int CW = $clog2(N + PE_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_RHS,
        S_WAIT_LHS,
        S_PROC,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] rhs_cnt_q, rhs_cnt_d;
    logic [CW-1:0] proc_cnt_q, proc_cnt_d;
    logic [BW-1:0] out_cnt_q, out_cnt_d;

    logic rhs_last;
    logic proc_last;
    logic out_last;

    assign rhs_last  = (rhs_cnt_q == BW'(N/4 - 1));
    assign proc_last = (proc_cnt_q == CW'(N + PE_DELAY - 1));
    assign out_last  = (out_cnt_q == BW'(N/4 - 1));

    // State and counter registers; reset aborts any pass back to IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rhs_cnt_q  <= '0;
            proc_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rhs_cnt_q  <= rhs_cnt_d;
            proc_cnt_q <= proc_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // Next-state and counter sequencing; counters sit at 0 outside their own state
    always_comb begin
        state_d    = state_q;
        rhs_cnt_d  = '0;
        proc_cnt_d = '0;
        out_cnt_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (rhs_start) state_d = S_LOAD_RHS;
            end
            S_LOAD_RHS: begin
                if (rhs_last) state_d = S_WAIT_LHS;
                else          rhs_cnt_d = rhs_cnt_q + 1'b1;
            end
            S_WAIT_LHS: begin
                if (lhs_start) state_d = S_PROC;
            end
            S_PROC: begin
                if (proc_last) state_d = S_DRAIN;
                else           proc_cnt_d = proc_cnt_q + 1'b1;
            end
            S_DRAIN: begin
                out_cnt_d = out_cnt_q;
                if (out_start) begin
                    if (out_last) state_d = keep_rhs ? S_WAIT_LHS : S_IDLE;
                    out_cnt_d = out_last ? '0 : out_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath controls decoded from state and counters only (tile_done excepted)
    always_comb begin
        rhs_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        rhs_we    = (state_q == S_LOAD_RHS);
        rhs_beat  = rhs_cnt_q;
        lhs_ready = (state_q == S_WAIT_LHS);
        pe_clear  = (state_q == S_PROC) && (proc_cnt_q == '0);
        pe_en     = (state_q == S_PROC) && (proc_cnt_q < CW'(N));
        lhs_beat  = pe_en ? RW'(proc_cnt_q) : '0;
        cap_en    = (state_q == S_PROC) && (proc_cnt_q >= CW'(PE_DELAY));
        cap_row   = cap_en ? RW'(proc_cnt_q - CW'(PE_DELAY)) : '0;
        out_ready = (state_q == S_DRAIN);
        out_beat  = out_cnt_q;
        tile_done = (state_q == S_DRAIN) && out_start && out_last;
    end

endmodule

// File: tb/tb_spmm_tile_sequencer.sv
// Directed bench for spmm_tile_sequencer with N=16, PE_DELAY=2.
module tb_spmm_tile_sequencer;

    localparam int N  = 16;
    localparam int PD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       rhs_ready, rhs_start, rhs_we;
    logic [1:0] rhs_beat;
    logic       lhs_ready, lhs_start, keep_rhs;
    logic       pe_clear, pe_en, cap_en;
    logic [3:0] lhs_beat, cap_row;
    logic       out_ready, out_start;
    logic [1:0] out_beat;
    logic       tile_done, busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    spmm_tile_sequencer #(.N(N), .PE_DELAY(PD)) dut (
        .clock(clock), .reset(reset),
        .rhs_ready(rhs_ready), .rhs_start(rhs_start), .rhs_we(rhs_we), .rhs_beat(rhs_beat),
        .lhs_ready(lhs_ready), .lhs_start(lhs_start), .keep_rhs(keep_rhs),
        .pe_clear(pe_clear), .pe_en(pe_en), .lhs_beat(lhs_beat),
        .cap_en(cap_en), .cap_row(cap_row),
        .out_ready(out_ready), .out_start(out_start), .out_beat(out_beat),
        .tile_done(tile_done), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".rhs_ready"}, 32'(rhs_ready), 1);
        check_eq({tag, ".busy"},      32'(busy), 0);
        check_eq({tag, ".rhs_we"},    32'(rhs_we), 0);
        check_eq({tag, ".lhs_ready"}, 32'(lhs_ready), 0);
        check_eq({tag, ".pe_en"},     32'(pe_en), 0);
        check_eq({tag, ".cap_en"},    32'(cap_en), 0);
        check_eq({tag, ".out_ready"}, 32'(out_ready), 0);
        check_eq({tag, ".pe_clear"},  32'(pe_clear), 0);
        check_eq({tag, ".out_beat"},  32'(out_beat), 0);
    endtask

    // Called in an IDLE cycle; ends in the first WAIT_LHS cycle
    task automatic do_load(input string tag);
        rhs_start = 1'b1;
        tick();
        rhs_start = 1'b0;
        for (int k = 0; k < N/4; k++) begin
            check_eq({tag, ".rhs_we"},   32'(rhs_we), 1);
            check_eq({tag, ".rhs_beat"}, 32'(rhs_beat), 32'(k));
            check_eq({tag, ".busy"},     32'(busy), 1);
            tick();
        end
        check_eq({tag, ".rhs_we_end"}, 32'(rhs_we), 0);
        check_eq({tag, ".lhs_ready"},  32'(lhs_ready), 1);
    endtask

    // Called in a WAIT_LHS cycle; ends in the first DRAIN cycle
    task automatic do_proc(input string tag);
        int pe_cnt;
        int cap_cnt;
        pe_cnt  = 0;
        cap_cnt = 0;
        lhs_start = 1'b1;
        tick();
        lhs_start = 1'b0;
        for (int c = 0; c < N + PD; c++) begin
            check_eq({tag, ".pe_clear"},  32'(pe_clear), (c == 0) ? 1 : 0);
            check_eq({tag, ".pe_en"},     32'(pe_en), (c < N) ? 1 : 0);
            check_eq({tag, ".lhs_beat"},  32'(lhs_beat), (c < N) ? 32'(c) : 0);
            check_eq({tag, ".cap_en"},    32'(cap_en), (c >= PD) ? 1 : 0);
            check_eq({tag, ".cap_row"},   32'(cap_row), (c >= PD) ? 32'(c - PD) : 0);
            check_eq({tag, ".out_ready"}, 32'(out_ready), 0);
            if (pe_en)  pe_cnt++;
            if (cap_en) cap_cnt++;
            tick();
        end
        check_eq({tag, ".pe_cycles"},  32'(pe_cnt), N);
        check_eq({tag, ".cap_cycles"}, 32'(cap_cnt), N);
        check_eq({tag, ".out_ready"},  32'(out_ready), 1);
        check_eq({tag, ".pe_en_end"},  32'(pe_en), 0);
        check_eq({tag, ".cap_en_end"}, 32'(cap_en), 0);
        check_eq({tag, ".out_beat0"},  32'(out_beat), 0);
    endtask

    // Drain all beats back-to-back, keep_rhs applied on the final beat
    task automatic do_drain(input string tag, input logic keep);
        for (int b = 0; b < N/4; b++) begin
            check_eq({tag, ".out_beat"}, 32'(out_beat), 32'(b));
            out_start = 1'b1;
            keep_rhs  = (b == N/4 - 1) ? keep : 1'b0;
            #1;
            check_eq({tag, ".tile_done"}, 32'(tile_done), (b == N/4 - 1) ? 1 : 0);
            tick();
            out_start = 1'b0;
            keep_rhs  = 1'b0;
        end
    endtask

    logic [6:0] drain_pat;
    int         drain_exp_beat[7] = '{0, 1, 1, 1, 2, 3, 3};

    initial begin
        reset = 1'b1; rhs_start = 1'b0; lhs_start = 1'b0;
        keep_rhs = 1'b0; out_start = 1'b0;
        drain_pat = 7'b1011001;   // bit i = out_start in drain cycle i

        // Reset state
        tick();
        check_idle("reset_held");
        tick();
        reset = 1'b0;
        tick();
        check_idle("idle");

        // Stray handshakes in IDLE are dropped
        lhs_start = 1'b1; out_start = 1'b1;
        tick();
        lhs_start = 1'b0; out_start = 1'b0;
        check_idle("idle_stray");
        tick();
        check_idle("idle_stray2");

        // First tile: load, process, drain with stalls
        do_load("load1");
        tick();
        check_eq("wait_hold.lhs_ready", 32'(lhs_ready), 1);
        do_proc("proc1");
        for (int i = 0; i < 7; i++) begin
            check_eq("stall.out_beat", 32'(out_beat), 32'(drain_exp_beat[i]));
            check_eq("stall.out_ready", 32'(out_ready), 1);
            out_start = drain_pat[i];
            #1;
            check_eq("stall.tile_done", 32'(tile_done), (i == 6) ? 1 : 0);
            tick();
            out_start = 1'b0;
        end
        check_idle("after_tile1");

        // RHS reuse across two LHS tiles
        do_load("load2");
        do_proc("proc2");
        do_drain("drain2", 1'b1);
        check_eq("reuse.lhs_ready", 32'(lhs_ready), 1);
        check_eq("reuse.rhs_we",    32'(rhs_we), 0);
        check_eq("reuse.busy",      32'(busy), 1);
        check_eq("reuse.out_beat",  32'(out_beat), 0);
        tick();
        check_eq("reuse.rhs_we2",   32'(rhs_we), 0);
        do_proc("proc3");
        do_drain("drain3", 1'b0);
        check_idle("after_tile3");

        // Asynchronous reset in the middle of PROC
        do_load("load4");
        lhs_start = 1'b1;
        tick();
        lhs_start = 1'b0;
        repeat (5) tick();
        check_eq("mid.pe_en",    32'(pe_en), 1);
        check_eq("mid.cap_en",   32'(cap_en), 1);
        check_eq("mid.lhs_beat", 32'(lhs_beat), 5);
        check_eq("mid.cap_row",  32'(cap_row), 3);
        #2 reset = 1'b1;
        #1;
        check_eq("async.pe_en",     32'(pe_en), 0);
        check_eq("async.cap_en",    32'(cap_en), 0);
        check_eq("async.rhs_ready", 32'(rhs_ready), 1);
        check_eq("async.busy",      32'(busy), 0);
        #2 reset = 1'b0;
        tick();
        check_idle("after_reset");
        do_load("load5");

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
